// File: rtl/add_sequencer.sv
// add_sequencer: multi-cycle adder/subtractor. It processes one N-bit slice
// per clock, least-significant slice first, so an N*W-bit operation takes W cycles.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; the outputs hold the last completed result
// RUN   | one slice computed per cycle; start is ignored
// DONE  | one-cycle done pulse; start is accepted here for back-to-back operation
module add_sequencer #(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           op,
  input  logic [N*W-1:0] a,
  input  logic [N*W-1:0] b,
  output logic [N*W-1:0] sum,
  output logic           cout,
  output logic           ovf,
  output logic           busy,
  output logic           done
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [N*W-1:0] a_q;
  logic [N*W-1:0] b_q;
  logic [N*W-1:0] res_q;
  logic [N*W-1:0] res_nxt;
  logic [IW-1:0]  idx;
  logic           carry;
  logic           op_q;

  logic [N-1:0]   a_sl;
  logic [N-1:0]   b_sl;
  logic [N-1:0]   b_eff;
  logic [N:0]     s;
  logic           last;
  logic           accept;

  // Slice datapath: select the current slice, add it with the carry-in,
  // and merge the result into a copy of the working register.
  always_comb begin
    a_sl    = '0;
    b_sl    = '0;
    res_nxt = res_q;
    for (int i = 0; i < W; i++) begin
      if (idx == IW'(i)) begin
        a_sl = a_q[i*N +: N];
        b_sl = b_q[i*N +: N];
      end
    end
    b_eff = op_q ? ~b_sl : b_sl;
    s     = {1'b0, a_sl} + {1'b0, b_eff} + {{N{1'b0}}, carry};
    for (int i = 0; i < W; i++) begin
      if (idx == IW'(i)) begin
        res_nxt[i*N +: N] = s[N-1:0];
      end
    end
  end

  assign last   = (idx == IW'(W - 1));
  assign accept = start && ((state == IDLE) || (state == DONE));

  // Sequencer FSM with registered outputs. On the final slice the result is
  // taken from res_nxt, because the top slice is not yet stored in res_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      idx   <= '0;
      carry <= 1'b0;
      op_q  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (accept) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            carry <= op;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          res_q <= res_nxt;
          carry <= s[N];
          idx   <= idx + 1'b1;
          if (last) begin
            sum   <= res_nxt;
            cout  <= s[N];
            // Overflow: the operands (with B as effectively added) share a sign,
            // and the result's sign differs from it.
            ovf   <= (a_sl[N-1] == b_eff[N-1]) && (s[N-1] != a_sl[N-1]);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_sequencer.sv
// Testbench for add_sequencer (N=8, W=4). The stimulus pushes reference
// results into a queue. A monitor pops and compares on every done pulse and
// checks that the outputs hold between done pulses.
module tb_add_sequencer;

  localparam int N = 8;
  localparam int W = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic          op;
  logic [31:0]   a;
  logic [31:0]   b;
  logic [31:0]   sum;
  logic          cout;
  logic          ovf;
  logic          busy;
  logic          done;

  int            errors = 0;
  int            checks = 0;
  int            done_cnt = 0;
  logic [33:0]   sb_q[$];
  logic [33:0]   last_out = '0;

  add_sequencer #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {sum, cout, ovf}, computed with plain integer arithmetic.
  function automatic logic [33:0] ref_op(input logic o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, sr;
    logic [31:0] r;
    logic        c;
    logic        v;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!o) begin
      r  = x + y;
      c  = ({32'd0, x} + {32'd0, y}) > 64'h0000_0000_FFFF_FFFF;
      sr = sx + sy;
    end else begin
      r  = x - y;
      c  = (x >= y);
      sr = sx - sy;
    end
    v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {r, c, v};
  endfunction

  // Monitor: score each done pulse, and check that the outputs stay put otherwise.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        last_out = '0;
      end else if (done) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending operation at %0t", $time);
        end else begin
          chk("result", {30'd0, sum, cout, ovf}, {30'd0, sb_q.pop_front()});
        end
        last_out = {sum, cout, ovf};
      end else if ({sum, cout, ovf} !== last_out) begin
        chk("hold", {30'd0, sum, cout, ovf}, {30'd0, last_out});
        last_out = {sum, cout, ovf};
      end
    end
  end

  // The caller is positioned at a negedge. Drive start for one edge, then
  // wait (bounded) for done. Return the latency and the number of busy cycles.
  task automatic do_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output int bcnt);
    start = 1'b1; op = o; a = x; b = y;
    sb_q.push_back(ref_op(o, x, y));
    @(negedge clk);
    start = 1'b0;
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 50) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end
    chk("done_seen", {63'd0, done}, 64'd1);
  endtask

  initial begin
    int lat, bcnt, d0, gap;
    logic [31:0] pool [5];
    rst = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_sum",  {32'd0, sum}, 64'd0);
    chk("rst_flags", {60'd0, cout, ovf, busy, done}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic add: latency and busy width.
    do_op(1'b0, 32'h0000_00FF, 32'h0000_0001, lat, bcnt);
    chk("lat_add", lat, 4);
    chk("busy_cycles", bcnt, 4);
    chk("sum_100", {32'd0, sum}, 64'h100);
    chk("cout_ovf_100", {62'd0, cout, ovf}, 64'd0);

    @(negedge clk); do_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, lat, bcnt);
    @(negedge clk); do_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, lat, bcnt);
    chk("ovf_add", {63'd0, ovf}, 64'd1);
    @(negedge clk); do_op(1'b1, 32'h0000_0005, 32'h0000_0007, lat, bcnt);
    chk("sub_neg", {32'd0, sum}, 64'hFFFF_FFFE);
    @(negedge clk); do_op(1'b1, 32'h8000_0000, 32'h0000_0001, lat, bcnt);
    chk("sub_ovf", {62'd0, cout, ovf}, 64'd3);

    // A start pulse during RUN must be ignored.
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'h1111_1111; b = 32'h2222_2222;
    sb_q.push_back(ref_op(1'b0, 32'h1111_1111, 32'h2222_2222));
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; op = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
    @(negedge clk); start = 1'b0;
    lat = 2;
    while (!done && lat < 50) begin @(negedge clk); lat++; end
    chk("lat_ignore", lat, 4);
    repeat (8) @(negedge clk);
    chk("one_done", done_cnt - d0, 1);

    // Start held high through DONE: the next operation runs back-to-back.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'h0102_0304; b = 32'h1020_3040;
    sb_q.push_back(ref_op(1'b0, 32'h0102_0304, 32'h1020_3040));
    @(negedge clk);
    op = 1'b1; a = 32'h0000_1000; b = 32'h0000_2000;
    sb_q.push_back(ref_op(1'b1, 32'h0000_1000, 32'h0000_2000));
    lat = 0;
    while (!done && lat < 50) begin @(negedge clk); lat++; end
    chk("b2b_first", lat, 4);
    @(negedge clk); start = 1'b0;
    gap = 1;
    while (!done && gap < 50) begin @(negedge clk); gap++; end
    chk("b2b_gap", gap, 5);

    // Asynchronous reset during the second RUN cycle.
    @(negedge clk);
    d0 = done_cnt;
    start = 1'b1; op = 1'b0; a = 32'h1234_5678; b = 32'h1111_1111;
    sb_q.push_back(ref_op(1'b0, 32'h1234_5678, 32'h1111_1111));
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_sum", {32'd0, sum}, 64'd0);
    sb_q.delete();
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_no_done", done_cnt - d0, 0);
    rst = 1'b0;
    do_op(1'b0, 32'h0000_00AA, 32'h0000_0055, lat, bcnt);
    chk("lat_after_rst", lat, 4);
    chk("sum_after_rst", {32'd0, sum}, 64'hFF);

    // Randomized operations with corner-biased operands.
    pool[0] = 32'h0000_0000; pool[1] = 32'hFFFF_FFFF; pool[2] = 32'h8000_0000;
    pool[3] = 32'h7FFF_FFFF; pool[4] = 32'h0000_0001;
    for (int k = 0; k < 40; k++) begin
      logic [31:0] x, y;
      x = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      do_op(1'($urandom_range(0, 1)), x, y, lat, bcnt);
      chk("lat_rand", lat, 4);
    end

    repeat (4) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
